// File: rtl/spi_cmd_decoder_if.sv
// Bus between the SPI byte engine / core register fabric and spi_cmd_decoder.
// master: the side that drives SPI bytes and core data (byte engine + core).
// slave : the decoder itself.
interface spi_cmd_decoder_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  logic              spi_cs_active_i;
  logic              spi_rx_valid_i;
  logic [7:0]        spi_rx_byte_i;
  logic [DATA_W-1:0] result_i;
  logic [DATA_W-1:0] stream_i;
  logic [7:0]        instruction_o;
  logic [ADDR_W-1:0] address_o;
  logic [DATA_W-1:0] value_o;
  logic              cmd_valid_o;
  logic              err_o;
  logic [7:0]        spi_tx_byte_o;

  modport master (
    output spi_cs_active_i, spi_rx_valid_i, spi_rx_byte_i, result_i, stream_i,
    input  instruction_o, address_o, value_o, cmd_valid_o, err_o, spi_tx_byte_o
  );

  modport slave (
    input  spi_cs_active_i, spi_rx_valid_i, spi_rx_byte_i, result_i, stream_i,
    output instruction_o, address_o, value_o, cmd_valid_o, err_o, spi_tx_byte_o
  );
endinterface

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: turns a chip-select framed byte stream into
// WRITE/READ/STREAM commands with address auto-increment and selects the
// bytes returned on MISO.
// Optional feature: define SPI_CMD_CHECKSUM_EN to require an XOR check byte
// after every WRITE data word.
module spi_cmd_decoder #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) (
  input logic            clk_i,
  input logic            rst_i,
  spi_cmd_decoder_if.slave bus
);

  localparam int ADDR_B = ADDR_W / 8;
  localparam int DATA_B = DATA_W / 8;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_B - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_B - 1);

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_STREAM = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
`ifdef SPI_CMD_CHECKSUM_EN
    ST_CHK,
`endif
    ST_RDTX,
    ST_STTX,
    ST_DISCARD
  } state_t;

  state_t            r_state;
  logic [7:0]        r_opcode;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr_sh;   // address being assembled, then WRITE target
  logic [DATA_W-1:0] r_data_sh;   // write word being assembled
  logic [DATA_W-1:0] r_tx_sh;     // MISO shift register
  logic [1:0]        r_pend;      // 01: commit seen, 10: sample next edge
  logic [7:0]        r_instr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_value;
  logic              r_cmd_valid;
  logic              r_err;
`ifdef SPI_CMD_CHECKSUM_EN
  logic [7:0]        r_chk;
`endif

  logic [ADDR_W-1:0] w_addr_next;
  logic [DATA_W-1:0] w_data_next;
  logic              w_tx_active;

  assign w_addr_next = (r_addr_sh << 8) | ADDR_W'(bus.spi_rx_byte_i);
  assign w_data_next = (r_data_sh << 8) | DATA_W'(bus.spi_rx_byte_i);
  assign w_tx_active = (r_state == ST_RDTX) || (r_state == ST_STTX);

  // Frame decoder FSM with registered command outputs and MISO shifter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_opcode    <= '0;
      r_cnt       <= '0;
      r_addr_sh   <= '0;
      r_data_sh   <= '0;
      r_tx_sh     <= '0;
      r_pend      <= '0;
      r_instr     <= '0;
      r_addr      <= '0;
      r_value     <= '0;
      r_cmd_valid <= 1'b0;
      r_err       <= 1'b0;
`ifdef SPI_CMD_CHECKSUM_EN
      r_chk       <= '0;
`endif
    end else begin
      r_cmd_valid <= 1'b0;
      r_err       <= 1'b0;
      if (!bus.spi_cs_active_i) begin
        // Frame end: drop partial words and any byte strobed this cycle.
        r_state   <= ST_IDLE;
        r_cnt     <= '0;
        r_pend    <= '0;
        r_tx_sh   <= '0;
        r_data_sh <= '0;
      end else begin
        // Read/stream data is taken one cycle after the commit pulse so the
        // core has a full cycle to present data for the new address.
        if (r_pend == 2'b01) begin
          r_pend <= 2'b10;
        end else if (r_pend == 2'b10) begin
          r_pend  <= '0;
          r_tx_sh <= (r_state == ST_RDTX) ? bus.result_i : bus.stream_i;
        end

        if (bus.spi_rx_valid_i) begin
          case (r_state)
            ST_IDLE: begin
              r_opcode <= bus.spi_rx_byte_i;
              r_cnt    <= '0;
`ifdef SPI_CMD_CHECKSUM_EN
              r_chk    <= bus.spi_rx_byte_i;
`endif
              case (bus.spi_rx_byte_i)
                OP_WRITE, OP_READ: r_state <= ST_ADDR;
                OP_STREAM: begin
                  r_state     <= ST_STTX;
                  r_instr     <= OP_STREAM;
                  r_cmd_valid <= 1'b1;
                  r_pend      <= 2'b01;
                end
                OP_NOP: r_state <= ST_DISCARD;
                default: begin
                  r_err   <= 1'b1;
                  r_state <= ST_DISCARD;
                end
              endcase
            end
            ST_ADDR: begin
              r_addr_sh <= w_addr_next;
`ifdef SPI_CMD_CHECKSUM_EN
              r_chk     <= r_chk ^ bus.spi_rx_byte_i;
`endif
              if (r_cnt == ADDR_LAST) begin
                r_cnt <= '0;
                if (r_opcode == OP_WRITE) begin
                  r_state <= ST_WDATA;
                end else begin
                  r_state     <= ST_RDTX;
                  r_instr     <= OP_READ;
                  r_addr      <= w_addr_next;
                  r_cmd_valid <= 1'b1;
                  r_pend      <= 2'b01;
                end
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
            ST_WDATA: begin
              r_data_sh <= w_data_next;
`ifdef SPI_CMD_CHECKSUM_EN
              r_chk     <= r_chk ^ bus.spi_rx_byte_i;
`endif
              if (r_cnt == DATA_LAST) begin
                r_cnt <= '0;
`ifdef SPI_CMD_CHECKSUM_EN
                r_state <= ST_CHK;
`else
                r_instr     <= OP_WRITE;
                r_addr      <= r_addr_sh;
                r_value     <= w_data_next;
                r_cmd_valid <= 1'b1;
                r_addr_sh   <= r_addr_sh + 1'b1;
`endif
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
`ifdef SPI_CMD_CHECKSUM_EN
            ST_CHK: begin
              if (bus.spi_rx_byte_i == r_chk) begin
                r_instr     <= OP_WRITE;
                r_addr      <= r_addr_sh;
                r_value     <= r_data_sh;
                r_cmd_valid <= 1'b1;
                r_addr_sh   <= r_addr_sh + 1'b1;
                r_chk       <= '0;
                r_state     <= ST_WDATA;
              end else begin
                r_err   <= 1'b1;
                r_state <= ST_DISCARD;
              end
            end
`endif
            ST_RDTX: begin
              r_tx_sh <= r_tx_sh << 8;
              if (r_cnt == DATA_LAST) begin
                r_cnt       <= '0;
                r_addr      <= r_addr + 1'b1;
                r_cmd_valid <= 1'b1;
                r_pend      <= 2'b01;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
            ST_STTX: begin
              r_tx_sh <= r_tx_sh << 8;
              if (r_cnt == DATA_LAST) begin
                r_cnt       <= '0;
                r_instr     <= OP_STREAM;
                r_cmd_valid <= 1'b1;
                r_pend      <= 2'b01;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.instruction_o = r_instr;
  assign bus.address_o     = r_addr;
  assign bus.value_o       = r_value;
  assign bus.cmd_valid_o   = r_cmd_valid;
  assign bus.err_o         = r_err;
  assign bus.spi_tx_byte_o = w_tx_active ? r_tx_sh[DATA_W-1 -: 8] : 8'h00;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder (ADDR_W=24, DATA_W=32).
module tb_spi_cmd_decoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_cmd_decoder_if #(.ADDR_W(24), .DATA_W(32)) bus ();

  spi_cmd_decoder #(.ADDR_W(24), .DATA_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_cmd    = 0;
  int unsigned n_err    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse counters sampled 1 ns after the active edge.
  always @(posedge clk) begin
    #1;
    if (bus.cmd_valid_o === 1'b1) n_cmd++;
    if (bus.err_o === 1'b1) n_err++;
  end

  task automatic send(input logic [7:0] b, input int unsigned gap);
    bus.spi_rx_byte_i  = b;
    bus.spi_rx_valid_i = 1'b1;
    @(negedge clk);
    bus.spi_rx_valid_i = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic set_cs(input logic v);
    @(negedge clk);
    bus.spi_cs_active_i = v;
    @(negedge clk);
  endtask

  task automatic hdr(input logic [7:0] op, input logic [23:0] a, input int unsigned gap,
                     output logic [7:0] seed);
    send(op, gap);
    send(a[23:16], gap);
    send(a[15:8], gap);
    send(a[7:0], gap);
    seed = op ^ a[23:16] ^ a[15:8] ^ a[7:0];
  endtask

  task automatic write_word(input logic [31:0] w, input logic [7:0] seed, input int unsigned gap);
    for (int i = 0; i < 4; i++) send(w[31-8*i -: 8], gap);
`ifdef SPI_CMD_CHECKSUM_EN
    send(seed ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0], gap);
`else
    if (seed === 8'hxx) $display("seed unknown");
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  seed;
    logic [31:0] rd_word;
    logic [63:0] st_words;
    int unsigned base, ebase;

    rst = 1'b1;
    bus.spi_cs_active_i = 1'b0;
    bus.spi_rx_valid_i  = 1'b0;
    bus.spi_rx_byte_i   = 8'h00;
    bus.result_i        = '0;
    bus.stream_i        = '0;
    repeat (3) @(negedge clk);
    check("rst_instr", bus.instruction_o, 0);
    check("rst_addr",  bus.address_o, 0);
    check("rst_value", bus.value_o, 0);
    check("rst_cmd",   bus.cmd_valid_o, 0);
    check("rst_err",   bus.err_o, 0);
    check("rst_tx",    bus.spi_tx_byte_o, 0);
    rst = 1'b0;

    // Commit something, then reset in the middle of the next frame.
    base = n_cmd;
    set_cs(1'b1);
    hdr(8'h01, 24'h000040, 3, seed);
    write_word(32'h12345678, seed, 3);
    check("pre_addr",  bus.address_o, 24'h000040);
    check("pre_value", bus.value_o, 32'h12345678);
    check("pre_cnt",   n_cmd - base, 1);
    send(8'hAB, 3);
    #2 rst = 1'b1;
    @(negedge clk);
    check("midrst_instr", bus.instruction_o, 0);
    check("midrst_addr",  bus.address_o, 0);
    check("midrst_value", bus.value_o, 0);
    rst = 1'b0;
    set_cs(1'b0);

    // Single write after reset.
    base = n_cmd;
    set_cs(1'b1);
    hdr(8'h01, 24'h000010, 3, seed);
    write_word(32'hDEADBEEF, seed, 3);
    set_cs(1'b0);
    check("w1_cnt",   n_cmd - base, 1);
    check("w1_instr", bus.instruction_o, 8'h01);
    check("w1_addr",  bus.address_o, 24'h000010);
    check("w1_value", bus.value_o, 32'hDEADBEEF);

    // Burst write with auto-increment.
    base = n_cmd;
    set_cs(1'b1);
    hdr(8'h01, 24'h000020, 3, seed);
    write_word(32'h11111111, seed, 3);
    check("bw0_addr",  bus.address_o, 24'h000020);
    check("bw0_value", bus.value_o, 32'h11111111);
    write_word(32'h22222222, 8'h00, 3);
    check("bw1_addr",  bus.address_o, 24'h000021);
    check("bw1_value", bus.value_o, 32'h22222222);
    check("bw_cnt",    n_cmd - base, 2);
    set_cs(1'b0);

    // Read: four bytes shifted out MSB first, then next address.
    rd_word = 32'hCAFEF00D;
    bus.result_i = rd_word;
    base = n_cmd;
    set_cs(1'b1);
    hdr(8'h02, 24'h000030, 3, seed);
    check("rd_cnt0",  n_cmd - base, 1);
    check("rd_instr", bus.instruction_o, 8'h02);
    check("rd_addr0", bus.address_o, 24'h000030);
    check("rd_value", bus.value_o, 32'h22222222);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rd_tx%0d", i), bus.spi_tx_byte_o, rd_word[31-8*i -: 8]);
      send(8'hA5, 3);
    end
    check("rd_cnt1",  n_cmd - base, 2);
    check("rd_addr1", bus.address_o, 24'h000031);
    check("rd_tx_re", bus.spi_tx_byte_o, 8'hCA);
    set_cs(1'b0);
    check("idle_tx", bus.spi_tx_byte_o, 8'h00);

    // Stream: two samples, eight bytes.
    st_words = 64'h0102030405060708;
    bus.stream_i = 32'h01020304;
    base = n_cmd;
    set_cs(1'b1);
    send(8'h03, 3);
    check("st_cnt0",  n_cmd - base, 1);
    check("st_instr", bus.instruction_o, 8'h03);
    check("st_addr",  bus.address_o, 24'h000031);
    check("st_value", bus.value_o, 32'h22222222);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("st_tx%0d", i), bus.spi_tx_byte_o, st_words[63-8*i -: 8]);
      if (i < 7) send(8'h5A, 3);
      if (i == 0) bus.stream_i = 32'h05060708;
    end
    check("st_cnt1", n_cmd - base, 2);
    set_cs(1'b0);

    // Invalid opcode: error, rest of frame ignored.
    base = n_cmd; ebase = n_err;
    set_cs(1'b1);
    send(8'h7F, 3);
    check("bad_err", n_err - ebase, 1);
    send(8'h02, 3); send(8'h00, 3); send(8'h00, 3); send(8'h40, 3);
    check("bad_cmd",  n_cmd - base, 0);
    check("bad_err1", n_err - ebase, 1);
    set_cs(1'b0);

    // CS drop after two address bytes: nothing changes.
    base = n_cmd;
    set_cs(1'b1);
    send(8'h02, 3); send(8'h00, 3); send(8'h00, 3);
    set_cs(1'b0);
    repeat (3) @(negedge clk);
    check("drop_cnt",   n_cmd - base, 0);
    check("drop_instr", bus.instruction_o, 8'h03);
    check("drop_addr",  bus.address_o, 24'h000031);
    check("drop_value", bus.value_o, 32'h22222222);

    // NOP frame: no command, no error.
    base = n_cmd; ebase = n_err;
    set_cs(1'b1);
    send(8'h00, 3); send(8'h01, 3); send(8'h00, 3);
    set_cs(1'b0);
    check("nop_cmd", n_cmd - base, 0);
    check("nop_err", n_err - ebase, 0);

    // Back-to-back strobes with address wrap.
    base = n_cmd;
    set_cs(1'b1);
    hdr(8'h01, 24'hFFFFFF, 0, seed);
    write_word(32'hAAAA5555, seed, 0);
    write_word(32'h0BADF00D, 8'h00, 0);
    repeat (3) @(negedge clk);
    check("wrap_cnt",   n_cmd - base, 2);
    check("wrap_addr",  bus.address_o, 24'h000000);
    check("wrap_value", bus.value_o, 32'h0BADF00D);
    set_cs(1'b0);

    // CS drop mid data word: partial word discarded.
    base = n_cmd;
    set_cs(1'b1);
    hdr(8'h01, 24'h000050, 3, seed);
    send(8'h99, 3); send(8'h88, 3);
    set_cs(1'b0);
    check("part_cnt",   n_cmd - base, 0);
    check("part_addr",  bus.address_o, 24'h000000);
    check("part_value", bus.value_o, 32'h0BADF00D);

`ifdef SPI_CMD_CHECKSUM_EN
    base = n_cmd; ebase = n_err;
    set_cs(1'b1);
    send(8'h01, 3); send(8'h00, 3); send(8'h00, 3); send(8'h01, 3);
    send(8'h00, 3); send(8'h00, 3); send(8'h00, 3); send(8'h05, 3);
    send(8'h05, 3);
    set_cs(1'b0);
    check("ck_ok_cnt",   n_cmd - base, 1);
    check("ck_ok_err",   n_err - ebase, 0);
    check("ck_ok_addr",  bus.address_o, 24'h000001);
    check("ck_ok_value", bus.value_o, 32'h00000005);
    base = n_cmd; ebase = n_err;
    set_cs(1'b1);
    send(8'h01, 3); send(8'h00, 3); send(8'h00, 3); send(8'h01, 3);
    send(8'h00, 3); send(8'h00, 3); send(8'h00, 3); send(8'h07, 3);
    send(8'h06, 3);
    set_cs(1'b0);
    check("ck_bad_cnt",   n_cmd - base, 0);
    check("ck_bad_err",   n_err - ebase, 1);
    check("ck_bad_value", bus.value_o, 32'h00000005);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
